// File: rtl/ntt_sched_if.sv
// Client and core signal bundle for the shared ntt scheduler.
// slave = scheduler side, master = requesters plus core.
interface ntt_sched_if #(
    parameter int DW   = 32,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_intt;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ld;
    logic [7:0]         idx;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;
    logic               busy;
    logic               core_rst;
    logic               core_ready;
    logic               core_intt;
    logic [DW-1:0]      core_din;
    logic               core_valid;
    logic [DW-1:0]      core_dout;

    modport slave (
        input  req, req_intt, req_data,
        input  core_valid, core_dout,
        output gnt, ld, idx, rsp_valid, rsp_data,
        output done, err, busy,
        output core_rst, core_ready, core_intt, core_din
    );

    modport master (
        output req, req_intt, req_data,
        output core_valid, core_dout,
        input  gnt, ld, idx, rsp_valid, rsp_data,
        input  done, err, busy,
        input  core_rst, core_ready, core_intt, core_din
    );
endinterface

// File: rtl/ntt_sched.sv
// Round-robin scheduler sharing one streaming ntt core among NREQ clients.
// Job = grant, load N coeffs, wait for core, route N results back.
module ntt_sched #(
    parameter int N       = 256,
    parameter int DW      = 32,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    ntt_sched_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT, DRAIN, ABORT
    } state_t;

    state_t state, state_nx;

    logic [GW-1:0]   rr;
    logic [GW-1:0]   gsel;
    logic [GW-1:0]   gsel_inc;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic            found;
    logic [NREQ-1:0] gnt_q;
    logic            intt;
    logic [8:0]      cnt;
    logic [WW-1:0]   wdog;
    logic            abort_2nd;
    logic            core_ready_q;
    logic [DW-1:0]   core_din_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;
    logic [7:0]      rsp_idx;
    logic [NREQ-1:0] done_q;
    logic            last_ld;
    logic            last_beat;
    logic            expire;

    // First requester at or after the round-robin pointer.
    always_comb begin
        pick  = rr;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = GW'((int'(rr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign gsel_inc = (int'(gsel) == NREQ - 1) ? '0 : gsel + 1'b1;

    assign last_ld   = (cnt == 9'(N - 1));
    assign last_beat = (state == DRAIN) && bus.core_valid
                       && (cnt == 9'(N - 1));
    assign expire    = !bus.core_valid && (wdog == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (found) state_nx = LOAD;
            LOAD:  if (last_ld) state_nx = WAIT;
            WAIT: begin
                if (bus.core_valid) state_nx = DRAIN;
                else if (expire)    state_nx = ABORT;
            end
            DRAIN: begin
                if (last_beat)   state_nx = IDLE;
                else if (expire) state_nx = ABORT;
            end
            ABORT: if (abort_2nd) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q        <= '0;
            gsel         <= '0;
            rr           <= '0;
            intt         <= 1'b0;
            cnt          <= '0;
            wdog         <= '0;
            abort_2nd    <= 1'b0;
            core_ready_q <= 1'b0;
            core_din_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_idx      <= '0;
            done_q       <= '0;
        end else begin
            core_ready_q <= 1'b0;
            rsp_valid_q  <= '0;
            done_q       <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gsel  <= pick;
                        gnt_q <= NREQ'(1) << pick;
                        intt  <= bus.req_intt[pick];
                        cnt   <= '0;
                        wdog  <= '0;
                    end
                end
                LOAD: begin
                    core_ready_q <= 1'b1;
                    core_din_q   <= bus.req_data[int'(gsel)*DW +: DW];
                    cnt          <= last_ld ? 9'd0 : cnt + 9'd1;
                end
                WAIT, DRAIN: begin
                    if (bus.core_valid) begin
                        rsp_valid_q <= gnt_q;
                        rsp_data_q  <= bus.core_dout;
                        rsp_idx     <= (state == WAIT) ? 8'd0 : cnt[7:0];
                        cnt         <= (state == WAIT) ? 9'd1 : cnt + 9'd1;
                        wdog        <= '0;
                        if (last_beat) begin
                            done_q <= gnt_q;
                            gnt_q  <= '0;
                            rr     <= gsel_inc;
                            intt   <= 1'b0;
                            cnt    <= '0;
                        end
                    end else if (expire) begin
                        gnt_q <= '0;
                        rr    <= gsel_inc;
                        wdog  <= '0;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                ABORT: begin
                    abort_2nd <= ~abort_2nd;
                    if (abort_2nd) intt <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.ld         = (state == LOAD) ? gnt_q : '0;
    // Load beats index from the live counter, response beats from their latch.
    assign bus.idx        = (state == LOAD) ? cnt[7:0] : rsp_idx;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.done       = done_q;
    assign bus.err        = (state == ABORT && !abort_2nd)
                            ? (NREQ'(1) << gsel) : '0;
    assign bus.busy       = (state != IDLE);
    assign bus.core_rst   = ~rst_n | (state == ABORT);
    assign bus.core_ready = core_ready_q;
    assign bus.core_intt  = intt;
    assign bus.core_din   = core_din_q;
endmodule

// File: tb/tb_ntt_sched.sv
// Scoreboard bench for ntt_sched: directed jobs, behavioural core model,
// negedge monitor popping expected beats and job outcomes.
module tb_ntt_sched;
    localparam int N       = 256;
    localparam int DW      = 32;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 64;

    typedef struct {
        int          g;
        int          idx;
        logic [31:0] d;
    } rsp_t;

    typedef struct {
        int g;
        bit m;
        bit ab;
    } job_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_ready = 0;
    int rst_run = 0;
    int n_rsp = 0;

    rsp_t sb[$];
    job_t job_q[$];

    logic [31:0] base0 = 0;
    logic [31:0] base1 = 0;
    bit          mute = 1'b0;
    bit          stray = 1'b0;
    int          gap = 0;

    int          n_in = 0;
    int          n_out = 0;
    int          gap_left = 0;
    logic [31:0] cap[N];
    logic        cmode = 1'b0;
    logic        nv;
    logic [31:0] nd;

    ntt_sched_if #(.DW(DW), .NREQ(NREQ)) bus ();

    ntt_sched #(
        .N(N), .DW(DW), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Requesters present base + index whenever asked.
    always_comb begin
        bus.req_data = {base1 + 32'(bus.idx), base0 + 32'(bus.idx)};
    end

    function automatic logic [31:0] core_fn(logic [31:0] x, logic m);
        return m ? (x * 32'd7 + 32'd13) : (x ^ 32'hA5A5_0000);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(string name, logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    task automatic push_job(int g, bit m, logic [31:0] b, bit ab);
        job_q.push_back('{g: g, m: m, ab: ab});
        if (!ab)
            for (int i = 0; i < N; i++)
                sb.push_back('{g: g, idx: i, d: core_fn(b + 32'(i), m)});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_intt = '0;
        sb.delete();
        job_q.delete();
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_ld", 32'(bus.ld), 0);
        chk("rst_idx", 32'(bus.idx), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_core_ready", 32'(bus.core_ready), 0);
        chk("rst_core_din", bus.core_din, 0);
        chk("rst_core_intt", 32'(bus.core_intt), 0);
        chk("rst_core_rst", 32'(bus.core_rst), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_gnt(int g);
        int n = 0;
        while (!bus.gnt[g] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_gnt_in_budget", 32'(n < 2000), 1);
    endtask

    task automatic wait_ld(int g, int v);
        int n = 0;
        while (!(bus.ld[g] && int'(bus.idx) == v) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ld_in_budget", 32'(n < 2000), 1);
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while ((sb.size() != 0 || job_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("job_in_budget", 32'(n < budget), 1);
        if (n >= budget) begin
            sb.delete();
            job_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Streaming core model: takes N strobes, then returns N results.
    initial begin
        bus.core_valid = 1'b0;
        bus.core_dout = '0;
        forever begin
            @(posedge clk);
            nv = 1'b0;
            nd = '0;
            if (bus.core_rst) begin
                n_in = 0;
                n_out = 0;
                gap_left = 0;
            end else begin
                if (bus.core_ready) begin
                    if (n_in < N) begin
                        cap[n_in] = bus.core_din;
                        cmode = bus.core_intt;
                        n_in++;
                    end else begin
                        bad("strobe_extra", bus.core_din);
                    end
                end else if (n_in > 0 && n_in < N) begin
                    chk("strobe_contiguous", 32'(n_in), N);
                    n_in = 0;
                end
                if (!mute && n_in == N) begin
                    if (gap_left == 0) begin
                        nv = 1'b1;
                        nd = core_fn(cap[n_out], cmode);
                        n_out++;
                        gap_left = gap;
                        if (n_out == N) begin
                            n_in = 0;
                            n_out = 0;
                        end
                    end else begin
                        gap_left--;
                    end
                end
                if (stray) begin
                    nv = 1'b1;
                    nd = 32'hDEAD_BEEF;
                end
            end
            #1;
            bus.core_valid = nv;
            bus.core_dout = nd;
        end
    end

    always @(negedge clk) begin
        job_t j;
        rsp_t e;
        if (!rst_n) begin
            n_rsp = 0;
            rst_run = 0;
        end else begin
            if (bus.core_ready) last_ready = cyc;
            if (bus.core_rst) begin
                rst_run++;
            end else if (rst_run != 0) begin
                chk("core_rst_len", 32'(rst_run), 2);
                rst_run = 0;
            end
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
            if (!bus.busy) chk("intt_idle", 32'(bus.core_intt), 0);
            if (bus.gnt != 0) begin
                if (job_q.size() == 0) begin
                    bad("gnt_unexpected", 32'(bus.gnt));
                end else begin
                    chk("gnt_route", 32'(bus.gnt), 32'(1) << job_q[0].g);
                    chk("intt_job", 32'(bus.core_intt), 32'(job_q[0].m));
                end
            end
            if (bus.rsp_valid != 0) begin
                if (sb.size() == 0) begin
                    bad("rsp_unexpected", bus.rsp_data);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_route", 32'(bus.rsp_valid), 32'(1) << e.g);
                    chk("rsp_idx", 32'(bus.idx), 32'(e.idx));
                    chk("rsp_data", bus.rsp_data, e.d);
                    n_rsp++;
                end
            end
            if (bus.done != 0) begin
                if (job_q.size() == 0) begin
                    bad("done_unexpected", 32'(bus.done));
                end else begin
                    j = job_q.pop_front();
                    chk("done_route", 32'(bus.done), 32'(1) << j.g);
                    chk("done_not_abort", 32'(j.ab), 0);
                    chk("done_beats", 32'(n_rsp), N);
                end
                n_rsp = 0;
            end
            if (bus.err != 0) begin
                if (job_q.size() == 0) begin
                    bad("err_unexpected", 32'(bus.err));
                end else begin
                    j = job_q.pop_front();
                    chk("err_route", 32'(bus.err), 32'(1) << j.g);
                    chk("err_expected", 32'(j.ab), 1);
                    chk("err_delay", 32'(cyc - last_ready), TIMEOUT);
                    chk("err_beats", 32'(n_rsp), 0);
                end
                n_rsp = 0;
            end
        end
    end

    initial begin
        bus.req = '0;
        bus.req_intt = '0;
        #3;
        do_reset();

        // 1: single forward job from requester 0, data = index
        base0 = 0;
        push_job(0, 1'b0, 0, 1'b0);
        bus.req[0] = 1'b1;
        wait_gnt(0);
        bus.req[0] = 1'b0;
        wait_drain(3000);

        // 2: simultaneous requests, round robin over two rounds
        do_reset();
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            base0 = 32'(1000 + 2000 * r);
            base1 = 32'(2000 + 2000 * r);
            push_job(0, 1'b0, base0, 1'b0);
            push_job(1, 1'b0, base1, 1'b0);
            bus.req = 2'b11;
            wait_gnt(0);
            bus.req[0] = 1'b0;
            wait_gnt(1);
            bus.req[1] = 1'b0;
            wait_drain(3000);
        end

        // 3: inverse job on requester 1, mode change after grant ignored
        base1 = 5000;
        push_job(1, 1'b1, base1, 1'b0);
        bus.req_intt[1] = 1'b1;
        bus.req[1] = 1'b1;
        wait_gnt(1);
        bus.req[1] = 1'b0;
        bus.req_intt[1] = 1'b0;
        wait_drain(3000);

        // 4: gapped core output plus a stray core beat during load
        gap = 3;
        base0 = 600;
        push_job(0, 1'b0, base0, 1'b0);
        bus.req[0] = 1'b1;
        wait_gnt(0);
        bus.req[0] = 1'b0;
        wait_ld(0, 50);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        wait_drain(4000);
        gap = 0;

        // 5: silent core -> abort, then a normal job on requester 1
        mute = 1'b1;
        push_job(0, 1'b0, base0, 1'b1);
        bus.req[0] = 1'b1;
        wait_gnt(0);
        bus.req[0] = 1'b0;
        wait_drain(1000);
        mute = 1'b0;
        base1 = 800;
        push_job(1, 1'b0, base1, 1'b0);
        bus.req[1] = 1'b1;
        wait_gnt(1);
        bus.req[1] = 1'b0;
        wait_drain(3000);

        // 6: async reset in the middle of loading, then a fresh job
        base0 = 0;
        push_job(0, 1'b0, base0, 1'b0);
        bus.req[0] = 1'b1;
        wait_gnt(0);
        bus.req[0] = 1'b0;
        wait_ld(0, 100);
        #2;
        do_reset();
        repeat (4) @(negedge clk);
        base0 = 10;
        push_job(0, 1'b0, base0, 1'b0);
        bus.req[0] = 1'b1;
        wait_gnt(0);
        bus.req[0] = 1'b0;
        wait_drain(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got cycle %0d expected end", cyc);
        $fatal(1, "bench did not finish");
    end
endmodule
